bp_be_mem_tracker: RTL

Parametrised memory-pipe request tracker for the BE calculator. It carries every issued memory op through a configurable-depth pipeline and resolves translation and cache results at a fixed commit stage. It performs natural-alignment checks, which were previously stubbed to zero, and prioritises load/store exceptions. It also gates the D$ ptag-valid and keeps saturating miss and exception counters.

---
 rtl/bp_be_pkg.sv | 37 +++
 rtl/bp_be_mem_align_check.sv | 21 ++
 rtl/bp_be_mem_tracker.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/bp_be_pkg.sv
// Shared types for the BE memory pipe: access size and privilege encodings,
// and the per-entry exception/status flag bundle carried down the tracker pipeline.
package bp_be_pkg;

    typedef enum logic [1:0] {
        e_size_b = 2'd0,
        e_size_h = 2'd1,
        e_size_w = 2'd2,
        e_size_d = 2'd3
    } bp_be_size_e;

    typedef enum logic [1:0] {
        e_priv_u    = 2'd0,
        e_priv_s    = 2'd1,
        e_priv_rsvd = 2'd2,
        e_priv_m    = 2'd3
    } bp_be_priv_e;

    // At most one of the six exception bits is ever set for an entry
    typedef struct packed {
        logic load_misaligned;
        logic store_misaligned;
        logic load_page_fault;
        logic store_page_fault;
        logic load_access_fault;
        logic store_access_fault;
        logic tlb_miss;
        logic fencei;
    } bp_be_mem_flags_s;

    function automatic logic any_exception(bp_be_mem_flags_s f);
        return f.load_misaligned | f.store_misaligned
             | f.load_page_fault | f.store_page_fault
             | f.load_access_fault | f.store_access_fault;
    endfunction

endpackage

// File: rtl/bp_be_mem_align_check.sv
// Natural-alignment check: an access of 2^size bytes must have its low size
// address bits clear. Only the low three address bits can ever matter.
module bp_be_mem_align_check
    import bp_be_pkg::*;
(
    input  logic [1:0] size_i,
    input  logic [2:0] offset_i,
    output logic       misaligned_o
);

    always_comb begin
        misaligned_o = 1'b0;
        case (size_i)
            e_size_h: misaligned_o = offset_i[0];
            e_size_w: misaligned_o = |offset_i[1:0];
            e_size_d: misaligned_o = |offset_i[2:0];
            default:  misaligned_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/bp_be_mem_tracker.sv
// Memory-pipe request tracker: computes the vaddr at issue, resolves alignment,
// TLB and PMA results at stage 1, and presents prioritised flags at the final stage.
module bp_be_mem_tracker
    import bp_be_pkg::*;
#(
    parameter int vaddr_width_p = 39,
    parameter int latency_p     = 2,
    parameter int cnt_width_p   = 16
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     v_i,
    input  logic [1:0]               size_i,
    input  logic                     store_i,
    input  logic                     fencei_i,
    input  logic [vaddr_width_p-1:0] rs1_i,
    input  logic [vaddr_width_p-1:0] imm_i,
    input  logic                     offset_sel_i,
    input  logic                     kill_ex1_i,
    input  logic                     flush_i,
    input  logic                     tlb_v_i,
    input  logic                     tlb_miss_i,
    input  logic                     tlb_u_i,
    input  logic                     tlb_w_i,
    input  logic                     tlb_d_i,
    input  logic                     uncached_i,
    input  logic                     did_fault_i,
    input  logic                     translation_en_i,
    input  logic                     mstatus_sum_i,
    input  logic                     uncached_mode_i,
    input  logic [1:0]               priv_mode_i,
    input  logic                     cache_v_i,
    input  logic                     clear_cnt_i,
    output logic [vaddr_width_p-1:0] vaddr_o,
    output logic                     ptag_v_o,
    output logic                     resp_v_o,
    output logic [vaddr_width_p-1:0] resp_vaddr_o,
    output logic                     load_misaligned_o,
    output logic                     store_misaligned_o,
    output logic                     load_page_fault_o,
    output logic                     store_page_fault_o,
    output logic                     load_access_fault_o,
    output logic                     store_access_fault_o,
    output logic                     tlb_miss_o,
    output logic                     cache_miss_o,
    output logic                     fencei_v_o,
    output logic [cnt_width_p-1:0]   miss_cnt_o,
    output logic [cnt_width_p-1:0]   exc_cnt_o
);

    logic [vaddr_width_p-1:0] vaddr;
    logic                     misaligned_s0;

    assign vaddr   = rs1_i + (offset_sel_i ? '0 : imm_i);
    assign vaddr_o = vaddr;

    bp_be_mem_align_check align_check (
        .size_i       (size_i),
        .offset_i     (vaddr[2:0]),
        .misaligned_o (misaligned_s0)
    );

    logic                     s1_v;
    logic                     s1_store;
    logic                     s1_fencei;
    logic                     s1_misaligned;
    logic [vaddr_width_p-1:0] s1_vaddr;

    // fence.i performs no address checks, so its misaligned bit is never set
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            s1_v          <= 1'b0;
            s1_store      <= 1'b0;
            s1_fencei     <= 1'b0;
            s1_misaligned <= 1'b0;
            s1_vaddr      <= '0;
        end else begin
            s1_v          <= v_i & ~flush_i;
            s1_store      <= store_i;
            s1_fencei     <= fencei_i;
            s1_misaligned <= misaligned_s0 & ~fencei_i;
            s1_vaddr      <= vaddr;
        end
    end

    logic             priv_fault;
    logic             write_fault;
    logic             page_fault;
    logic             access_fault;
    bp_be_mem_flags_s s1_flags;

    assign priv_fault   = ((priv_mode_i == e_priv_s) & ~mstatus_sum_i & tlb_u_i)
                        | ((priv_mode_i == e_priv_u) & ~tlb_u_i);
    assign write_fault  = s1_store & (~tlb_w_i | ~tlb_d_i);
    assign page_fault   = tlb_v_i & translation_en_i & (priv_fault | write_fault);
    assign access_fault = tlb_v_i & ((uncached_mode_i & ~uncached_i) | did_fault_i);

    assign ptag_v_o = s1_v & ~s1_fencei & tlb_v_i & ~s1_misaligned
                    & ~page_fault & ~access_fault & ~kill_ex1_i;

    // Priority chain: misaligned, then tlb miss, then page fault, then access fault
    always_comb begin
        s1_flags = '0;
        if (s1_fencei) begin
            s1_flags.fencei = 1'b1;
        end else if (s1_misaligned) begin
            s1_flags.load_misaligned  = ~s1_store;
            s1_flags.store_misaligned = s1_store;
        end else if (tlb_miss_i) begin
            s1_flags.tlb_miss = 1'b1;
        end else if (page_fault) begin
            s1_flags.load_page_fault  = ~s1_store;
            s1_flags.store_page_fault = s1_store;
        end else if (access_fault) begin
            s1_flags.load_access_fault  = ~s1_store;
            s1_flags.store_access_fault = s1_store;
        end
    end

    logic                     pipe_v     [1:latency_p];
    logic [vaddr_width_p-1:0] pipe_vaddr [1:latency_p];
    bp_be_mem_flags_s         pipe_flags [1:latency_p];

    assign pipe_v[1]     = s1_v & ~kill_ex1_i;
    assign pipe_vaddr[1] = s1_vaddr;
    assign pipe_flags[1] = s1_flags;

    for (genvar i = 2; i <= latency_p; i++) begin : gen_stage
        logic                     v_r;
        logic [vaddr_width_p-1:0] vaddr_r;
        bp_be_mem_flags_s         flags_r;

        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                v_r     <= 1'b0;
                vaddr_r <= '0;
                flags_r <= '0;
            end else begin
                v_r     <= pipe_v[i-1] & ~flush_i;
                vaddr_r <= pipe_vaddr[i-1];
                flags_r <= pipe_flags[i-1];
            end
        end

        assign pipe_v[i]     = v_r;
        assign pipe_vaddr[i] = vaddr_r;
        assign pipe_flags[i] = flags_r;
    end

    bp_be_mem_flags_s resp_flags;
    logic             resp_exc;

    assign resp_v_o   = pipe_v[latency_p];
    assign resp_flags = pipe_flags[latency_p];
    assign resp_exc   = resp_v_o & any_exception(resp_flags);

    assign resp_vaddr_o         = resp_v_o ? pipe_vaddr[latency_p] : '0;
    assign load_misaligned_o    = resp_v_o & resp_flags.load_misaligned;
    assign store_misaligned_o   = resp_v_o & resp_flags.store_misaligned;
    assign load_page_fault_o    = resp_v_o & resp_flags.load_page_fault;
    assign store_page_fault_o   = resp_v_o & resp_flags.store_page_fault;
    assign load_access_fault_o  = resp_v_o & resp_flags.load_access_fault;
    assign store_access_fault_o = resp_v_o & resp_flags.store_access_fault;
    assign tlb_miss_o           = resp_v_o & resp_flags.tlb_miss;
    assign cache_miss_o         = resp_v_o & ~cache_v_i & ~any_exception(resp_flags)
                                & ~resp_flags.tlb_miss & ~resp_flags.fencei;
    assign fencei_v_o           = resp_v_o & resp_flags.fencei & cache_v_i;

    // Counters hold at all-ones; a clear in the same cycle overrides any increment
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            miss_cnt_o <= '0;
            exc_cnt_o  <= '0;
        end else if (clear_cnt_i) begin
            miss_cnt_o <= '0;
            exc_cnt_o  <= '0;
        end else begin
            if ((cache_miss_o | tlb_miss_o) & ~&miss_cnt_o)
                miss_cnt_o <= miss_cnt_o + cnt_width_p'(1);
            if (resp_exc & ~&exc_cnt_o)
                exc_cnt_o <= exc_cnt_o + cnt_width_p'(1);
        end
    end

endmodule
